// File: rtl/alu_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : alu_sched_pkg
//  Brief    : Shared op codes, FSM state encoding and flag bit positions for
//             the ALU scheduler and its shared 32-bit ALU.
//  Revision : 1.0  initial release
// ============================================================================
package alu_sched_pkg;

    // ALU op codes
    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ROR = 2'b11;

    // Bit positions inside the {N,Z,C,V} nibble
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // Scheduler FSM states
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_EXEC_LO = 2'd1,
        S_EXEC_HI = 2'd2,
        S_RESP    = 2'd3
    } state_t;

    // SUB and ROR have no 64-bit form; requesting one is an error
    function automatic logic is_illegal_wide(input logic [1:0] op);
        return (op == ALU_SUB) || (op == ALU_ROR);
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu.sv
`default_nettype none
// ============================================================================
//  Module   : alu
//  Brief    : 32-bit ALU. ADD with carry-in, SUB (in2-in1, C = no borrow),
//             AND, ROR (in2 rotated right by in1[4:0]). Produces N,Z,C,V.
//  Revision : 1.0  initial release
// ============================================================================
module alu
    import alu_sched_pkg::*;
(
    input  logic [31:0] i_in1,
    input  logic [31:0] i_in2,
    input  logic [1:0]  i_op,
    input  logic        i_cin,
    output logic [31:0] o_out,
    output logic        o_n,
    output logic        o_z,
    output logic        o_c,
    output logic        o_v
);

    logic [32:0] w_sum;
    logic [32:0] w_diff;
    logic [4:0]  w_amt;
    logic [31:0] w_rot;
    logic [31:0] w_res;

    assign w_sum  = {1'b0, i_in1} + {1'b0, i_in2} + {32'd0, i_cin};
    assign w_diff = {1'b0, i_in2} - {1'b0, i_in1};
    // Rotation uses only the low five bits; a shift by 32 yields zero when amt is 0
    assign w_amt  = i_in1[4:0];
    assign w_rot  = (i_in2 >> w_amt) | (i_in2 << (6'd32 - {1'b0, w_amt}));

    // Op decode: result, carry and overflow per op
    always_comb begin
        w_res = 32'd0;
        o_c   = 1'b0;
        o_v   = 1'b0;
        case (i_op)
            ALU_ADD: begin
                w_res = w_sum[31:0];
                o_c   = w_sum[32];
                o_v   = (i_in1[31] == i_in2[31]) && (w_sum[31] != i_in1[31]);
            end
            ALU_SUB: begin
                w_res = w_diff[31:0];
                o_c   = ~w_diff[32];
                o_v   = (i_in2[31] != i_in1[31]) && (w_diff[31] != i_in2[31]);
            end
            ALU_AND: begin
                w_res = i_in1 & i_in2;
            end
            default: begin
                w_res = w_rot;
                o_c   = (w_amt != 5'd0) ? w_rot[31] : 1'b0;
            end
        endcase
    end

    assign o_out = w_res;
    assign o_n   = w_res[31];
    assign o_z   = (w_res == 32'd0);

endmodule
`default_nettype wire

// File: rtl/alu_sched_rr_arb.sv
`default_nettype none
// ============================================================================
//  Module   : alu_sched_rr_arb
//  Brief    : Two-way round-robin arbiter. A lone requester always wins; on
//             contention the pointer selects the winner.
//  Revision : 1.0  initial release
// ============================================================================
module alu_sched_rr_arb (
    input  logic i_valid0,
    input  logic i_valid1,
    input  logic i_ptr,
    output logic o_any,
    output logic o_gnt
);

    assign o_any = i_valid0 | i_valid1;

    // Grant selection: pointer only matters when both request
    always_comb begin
        o_gnt = 1'b0;
        if (i_valid0 && i_valid1) begin
            o_gnt = i_ptr;
        end else if (i_valid1) begin
            o_gnt = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_sched.sv
`default_nettype none
// ============================================================================
//  Module   : alu_sched
//  Brief    : Shares one 32-bit ALU between two requesters with round-robin
//             arbitration, sequences 64-bit ops as two passes with carry
//             chaining, owns the NZCV register and returns results over a
//             valid/ready response channel.
//  Options  : ALU_SCHED_PERF_EN adds per-requester response counters.
//  Revision : 1.0  initial release
// ============================================================================
module alu_sched
    import alu_sched_pkg::*;
#(
    parameter logic RR_INIT = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        r0_valid,
    output logic        r0_ready,
    input  logic [1:0]  r0_op,
    input  logic        r0_wide,
    input  logic        r0_cin_en,
    input  logic [63:0] r0_a,
    input  logic [63:0] r0_b,
    input  logic        r1_valid,
    output logic        r1_ready,
    input  logic [1:0]  r1_op,
    input  logic        r1_wide,
    input  logic        r1_cin_en,
    input  logic [63:0] r1_a,
    input  logic [63:0] r1_b,
    output logic        rs_valid,
    input  logic        rs_ready,
    output logic        rs_id,
    output logic [63:0] rs_result,
    output logic [3:0]  rs_flags,
    output logic        rs_err,
`ifdef ALU_SCHED_PERF_EN
    output logic [15:0] perf_ops0,
    output logic [15:0] perf_ops1,
`endif
    output logic [3:0]  flags_nzcv
);

    state_t      r_state;
    state_t      w_state_nxt;

    logic        r_rr;
    logic        r_id;
    logic [1:0]  r_op;
    logic        r_wide;
    logic        r_cin_en;
    logic [63:0] r_a;
    logic [63:0] r_b;

    // Only the low-pass Z and C feed the high pass merge; N and V are superseded
    logic [31:0] r_lo_res;
    logic        r_lo_z;
    logic        r_lo_c;

    logic        w_any;
    logic        w_gnt;
    logic        w_accept;
    logic [1:0]  w_sel_op;
    logic        w_sel_wide;
    logic        w_sel_cin_en;
    logic [63:0] w_sel_a;
    logic [63:0] w_sel_b;
    logic        w_illegal;
    logic        w_hi;
    logic        w_finish;

    logic [31:0] w_alu_in1;
    logic [31:0] w_alu_in2;
    logic        w_alu_cin;
    logic [31:0] w_alu_out;
    logic        w_alu_n;
    logic        w_alu_z;
    logic        w_alu_c;
    logic        w_alu_v;

    logic [3:0]  w_new_flags;
    logic [63:0] w_new_result;

    alu_sched_rr_arb u_arb (
        .i_valid0 (r0_valid),
        .i_valid1 (r1_valid),
        .i_ptr    (r_rr),
        .o_any    (w_any),
        .o_gnt    (w_gnt)
    );

    alu u_alu (
        .i_in1 (w_alu_in1),
        .i_in2 (w_alu_in2),
        .i_op  (r_op),
        .i_cin (w_alu_cin),
        .o_out (w_alu_out),
        .o_n   (w_alu_n),
        .o_z   (w_alu_z),
        .o_c   (w_alu_c),
        .o_v   (w_alu_v)
    );

    assign w_accept     = (r_state == S_IDLE) && w_any;
    assign r0_ready     = w_accept && !w_gnt;
    assign r1_ready     = w_accept && w_gnt;

    assign w_sel_op     = w_gnt ? r1_op     : r0_op;
    assign w_sel_wide   = w_gnt ? r1_wide   : r0_wide;
    assign w_sel_cin_en = w_gnt ? r1_cin_en : r0_cin_en;
    assign w_sel_a      = w_gnt ? r1_a      : r0_a;
    assign w_sel_b      = w_gnt ? r1_b      : r0_b;
    assign w_illegal    = w_sel_wide && is_illegal_wide(w_sel_op);

    assign w_hi         = (r_state == S_EXEC_HI);
    assign w_finish     = ((r_state == S_EXEC_LO) && !r_wide) || w_hi;
    assign w_alu_in1    = w_hi ? r_a[63:32] : r_a[31:0];
    assign w_alu_in2    = w_hi ? r_b[63:32] : r_b[31:0];
    assign rs_valid     = (r_state == S_RESP);

    // Carry-in: high pass chains the low-pass carry, low pass optionally uses stored C
    always_comb begin
        w_alu_cin = 1'b0;
        if (r_op == ALU_ADD) begin
            if (w_hi) begin
                w_alu_cin = r_lo_c;
            end else begin
                w_alu_cin = r_cin_en && flags_nzcv[FLAG_C];
            end
        end
    end

    // Flag merge for the pass that completes the op
    always_comb begin
        w_new_flags         = 4'd0;
        w_new_flags[FLAG_N] = w_alu_n;
        w_new_flags[FLAG_Z] = w_hi ? (w_alu_z && r_lo_z) : w_alu_z;
        w_new_flags[FLAG_C] = w_alu_c;
        w_new_flags[FLAG_V] = w_alu_v;
        if (r_op == ALU_AND) begin
            w_new_flags[FLAG_C] = flags_nzcv[FLAG_C];
            w_new_flags[FLAG_V] = flags_nzcv[FLAG_V];
        end else if (r_op == ALU_ROR) begin
            w_new_flags[FLAG_V] = flags_nzcv[FLAG_V];
        end
    end

    assign w_new_result = w_hi ? {w_alu_out, r_lo_res} : {32'd0, w_alu_out};

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = w_illegal ? S_RESP : S_EXEC_LO;
                end
            end
            S_EXEC_LO: w_state_nxt = r_wide ? S_EXEC_HI : S_RESP;
            S_EXEC_HI: w_state_nxt = S_RESP;
            default: begin
                if (rs_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
        endcase
    end

    // Operand capture, pass results, response registers and the flag register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rr       <= RR_INIT;
            r_id       <= 1'b0;
            r_op       <= ALU_ADD;
            r_wide     <= 1'b0;
            r_cin_en   <= 1'b0;
            r_a        <= 64'd0;
            r_b        <= 64'd0;
            r_lo_res   <= 32'd0;
            r_lo_z     <= 1'b0;
            r_lo_c     <= 1'b0;
            rs_id      <= 1'b0;
            rs_result  <= 64'd0;
            rs_flags   <= 4'd0;
            rs_err     <= 1'b0;
            flags_nzcv <= 4'd0;
        end else begin
            if (w_accept) begin
                r_rr     <= !w_gnt;
                r_id     <= w_gnt;
                r_op     <= w_sel_op;
                r_wide   <= w_sel_wide;
                r_cin_en <= w_sel_cin_en;
                r_a      <= w_sel_a;
                r_b      <= w_sel_b;
                if (w_illegal) begin
                    rs_id     <= w_gnt;
                    rs_result <= 64'd0;
                    rs_flags  <= 4'd0;
                    rs_err    <= 1'b1;
                end
            end
            if (r_state == S_EXEC_LO) begin
                r_lo_res <= w_alu_out;
                r_lo_z   <= w_alu_z;
                r_lo_c   <= w_alu_c;
            end
            if (w_finish) begin
                rs_id      <= r_id;
                rs_result  <= w_new_result;
                rs_flags   <= w_new_flags;
                rs_err     <= 1'b0;
                flags_nzcv <= w_new_flags;
            end
        end
    end

`ifdef ALU_SCHED_PERF_EN
    // Saturating per-requester count of handshaken responses
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_ops0 <= 16'd0;
            perf_ops1 <= 16'd0;
        end else if (rs_valid && rs_ready) begin
            if (!rs_id && (perf_ops0 != 16'hFFFF)) begin
                perf_ops0 <= perf_ops0 + 16'd1;
            end
            if (rs_id && (perf_ops1 != 16'hFFFF)) begin
                perf_ops1 <= perf_ops1 + 16'd1;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_sched
//  Brief    : Scoreboard bench for alu_sched. Expected responses come from a
//             64-bit reference model at accept time and are compared when the
//             response appears.
//  Revision : 1.0  initial release
// ============================================================================
module tb_alu_sched;
    import alu_sched_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        r0_valid, r0_ready, r0_wide, r0_cin_en;
    logic [1:0]  r0_op;
    logic [63:0] r0_a, r0_b;
    logic        r1_valid, r1_ready, r1_wide, r1_cin_en;
    logic [1:0]  r1_op;
    logic [63:0] r1_a, r1_b;
    logic        rs_valid, rs_ready, rs_id, rs_err;
    logic [63:0] rs_result;
    logic [3:0]  rs_flags, flags_nzcv;
`ifdef ALU_SCHED_PERF_EN
    logic [15:0] perf_ops0, perf_ops1;
`endif

    always #5 clk = ~clk;

    alu_sched dut (
        .clk        (clk),
        .reset      (reset),
        .r0_valid   (r0_valid),
        .r0_ready   (r0_ready),
        .r0_op      (r0_op),
        .r0_wide    (r0_wide),
        .r0_cin_en  (r0_cin_en),
        .r0_a       (r0_a),
        .r0_b       (r0_b),
        .r1_valid   (r1_valid),
        .r1_ready   (r1_ready),
        .r1_op      (r1_op),
        .r1_wide    (r1_wide),
        .r1_cin_en  (r1_cin_en),
        .r1_a       (r1_a),
        .r1_b       (r1_b),
        .rs_valid   (rs_valid),
        .rs_ready   (rs_ready),
        .rs_id      (rs_id),
        .rs_result  (rs_result),
        .rs_flags   (rs_flags),
        .rs_err     (rs_err),
`ifdef ALU_SCHED_PERF_EN
        .perf_ops0  (perf_ops0),
        .perf_ops1  (perf_ops1),
`endif
        .flags_nzcv (flags_nzcv)
    );

    typedef struct packed {
        logic        id;
        logic [63:0] res;
        logic [3:0]  flg;
        logic        err;
        logic [3:0]  nzcv;
        logic [31:0] lat;
        logic [31:0] acc;
    } exp_t;

    exp_t        sb_q[$];
    logic        grant_log[$];
    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] cyc = 0;
    logic [3:0]  m_flags = 4'd0;
    logic [63:0] last_res;
    logic        seen = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, expv);
        end
    endtask

    // Reference model, computed on full-width operands
    function automatic void model(input logic [1:0] op, input logic wide, input logic cin_en,
                                  input logic [63:0] a, input logic [63:0] b, input logic [3:0] fin,
                                  output logic [63:0] res, output logic [3:0] f, output logic err);
        logic [64:0] s65;
        logic [32:0] s33;
        logic [31:0] a32, b32, r32;
        logic        cin, n, z, c, v;
        int          amt;
        err = wide && (op == ALU_SUB || op == ALU_ROR);
        cin = (op == ALU_ADD && cin_en) ? fin[1] : 1'b0;
        a32 = a[31:0];
        b32 = b[31:0];
        res = 64'd0;
        c = fin[1];
        v = fin[0];
        if (err) begin
            f = 4'd0;
            return;
        end
        if (wide) begin
            if (op == ALU_ADD) begin
                s65 = {1'b0, a} + {1'b0, b} + {64'd0, cin};
                res = s65[63:0];
                c = s65[64];
                v = (a[63] == b[63]) && (res[63] != a[63]);
            end else begin
                res = a & b;
            end
            n = res[63];
            z = (res == 64'd0);
        end else begin
            case (op)
                ALU_ADD: begin
                    s33 = {1'b0, a32} + {1'b0, b32} + {32'd0, cin};
                    r32 = s33[31:0];
                    c = s33[32];
                    v = (a32[31] == b32[31]) && (r32[31] != a32[31]);
                end
                ALU_SUB: begin
                    r32 = b32 - a32;
                    c = (b32 >= a32);
                    v = (b32[31] != a32[31]) && (r32[31] != b32[31]);
                end
                ALU_AND: r32 = a32 & b32;
                default: begin
                    amt = int'(a32[4:0]);
                    r32 = (amt == 0) ? b32 : ((b32 >> amt) | (b32 << (32 - amt)));
                    c = (amt != 0) ? r32[31] : 1'b0;
                end
            endcase
            res = {32'd0, r32};
            n = r32[31];
            z = (r32 == 32'd0);
        end
        f = {n, z, c, v};
    endfunction

    // Response monitor: compare each new response once against the scoreboard head
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            seen = 1'b0;
        end else begin
            if (rs_valid && !seen) begin
                chk("sb_nonempty", 64'(sb_q.size() != 0), 64'd1);
                if (sb_q.size() != 0) begin
                    e = sb_q.pop_front();
                    chk("rs_id", 64'(rs_id), 64'(e.id));
                    chk("rs_result", rs_result, e.res);
                    chk("rs_flags", 64'(rs_flags), 64'(e.flg));
                    chk("rs_err", 64'(rs_err), 64'(e.err));
                    chk("latency", 64'(cyc - e.acc), 64'(e.lat));
                    chk("flags_nzcv", 64'(flags_nzcv), 64'(e.nzcv));
                end
                seen = 1'b1;
            end
            if (rs_valid && rs_ready) seen = 1'b0;
        end
    end

    task automatic issue(input logic id, input logic [1:0] op, input logic wide,
                         input logic cin_en, input logic [63:0] a, input logic [63:0] b);
        exp_t        e;
        logic [63:0] r;
        logic [3:0]  f;
        logic        er;
        logic        got;
        got = 1'b0;
        if (id) begin
            r1_op = op; r1_wide = wide; r1_cin_en = cin_en; r1_a = a; r1_b = b; r1_valid = 1'b1;
        end else begin
            r0_op = op; r0_wide = wide; r0_cin_en = cin_en; r0_a = a; r0_b = b; r0_valid = 1'b1;
        end
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk);
            if (id ? r1_ready : r0_ready) got = 1'b1;
        end
        chk(id ? "r1_accept" : "r0_accept", 64'(got), 64'd1);
        if (got) begin
            model(op, wide, cin_en, a, b, m_flags, r, f, er);
            if (!er) m_flags = f;
            e.id   = id;
            e.res  = r;
            e.flg  = f;
            e.err  = er;
            e.nzcv = m_flags;
            e.lat  = er ? 32'd1 : (wide ? 32'd3 : 32'd2);
            e.acc  = cyc;
            sb_q.push_back(e);
            grant_log.push_back(id);
            last_res = r;
        end
        @(posedge clk);
        #1;
        if (id) r1_valid = 1'b0;
        else    r0_valid = 1'b0;
    endtask

    task automatic stream(input logic id, input int n);
        for (int k = 0; k < n; k++) begin
            issue(id, ALU_ADD, 1'b0, 1'b0, 64'(k * 3 + 1), 64'(id ? 100 : 200));
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 50 && sb_q.size() != 0; i++) @(negedge clk);
        chk("drain", 64'(sb_q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        sb_q.delete();
        m_flags = 4'd0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        r0_valid = 0; r0_op = 0; r0_wide = 0; r0_cin_en = 0; r0_a = 0; r0_b = 0;
        r1_valid = 0; r1_op = 0; r1_wide = 0; r1_cin_en = 0; r1_a = 0; r1_b = 0;
        rs_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        @(negedge clk);
        chk("rst_rs_valid", 64'(rs_valid), 64'd0);
        chk("rst_rs_result", rs_result, 64'd0);
        chk("rst_rs_flags", 64'(rs_flags), 64'd0);
        chk("rst_rs_err", 64'(rs_err), 64'd0);
        chk("rst_rs_id", 64'(rs_id), 64'd0);
        chk("rst_nzcv", 64'(flags_nzcv), 64'd0);
        chk("rst_ready", 64'({r0_ready, r1_ready}), 64'd0);
        @(posedge clk);
        #1;

        // Directed functional patterns
        issue(1'b0, ALU_ADD, 1'b0, 1'b0, 64'd5, 64'd7);
        issue(1'b1, ALU_ADD, 1'b1, 1'b0, 64'h0000_0000_FFFF_FFFF, 64'd1);
        issue(1'b0, ALU_ADD, 1'b0, 1'b0, 64'h8000_0000, 64'h8000_0000);
        issue(1'b0, ALU_ADD, 1'b0, 1'b1, 64'd0, 64'd0);
        issue(1'b1, ALU_SUB, 1'b1, 1'b0, 64'd1, 64'd9);
        issue(1'b1, ALU_SUB, 1'b0, 1'b0, 64'd3, 64'd10);
        issue(1'b0, ALU_SUB, 1'b0, 1'b0, 64'd10, 64'd3);
        issue(1'b0, ALU_AND, 1'b0, 1'b0, 64'hF0F0_F0F0, 64'h0FF0_0FF0);
        issue(1'b1, ALU_ROR, 1'b0, 1'b0, 64'd33, 64'h8000_0001);
        issue(1'b0, ALU_ROR, 1'b0, 1'b0, 64'd4, 64'h1234_5678);
        issue(1'b1, ALU_AND, 1'b1, 1'b0, 64'hFFFF_0000_0000_FFFF, 64'hF000_0000_0000_000F);
        issue(1'b0, ALU_ROR, 1'b1, 1'b0, 64'd1, 64'd2);
        issue(1'b1, ALU_ADD, 1'b1, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1);
        drain();

        // Contention from reset: grants must alternate starting at requester 0
        do_reset();
        grant_log.delete();
        fork
            stream(1'b0, 4);
            stream(1'b1, 4);
        join
        drain();
        chk("grant_count", 64'(grant_log.size()), 64'd8);
        for (int i = 0; i < grant_log.size(); i++) begin
            chk("grant_order", 64'(grant_log[i]), 64'(i % 2));
        end

        // Back-pressure: response held, no new accept while stalled
        rs_ready = 1'b0;
        issue(1'b0, ALU_AND, 1'b0, 1'b0, 64'hF0F0, 64'hFF00);
        @(posedge clk);
        #1;
        r1_op = ALU_ADD; r1_wide = 1'b0; r1_cin_en = 1'b0; r1_a = 64'd1; r1_b = 64'd1;
        r1_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_valid", 64'(rs_valid), 64'd1);
            chk("stall_result", rs_result, last_res);
            chk("stall_no_ready", 64'(r1_ready), 64'd0);
        end
        @(posedge clk);
        #1;
        r1_valid = 1'b0;
        rs_ready = 1'b1;
        drain();

        // Reset while the high pass of a wide op is executing
        issue(1'b0, ALU_ADD, 1'b1, 1'b0, 64'h1_0000_0001, 64'h2_0000_0002);
        @(posedge clk);
        #1;
        chk("in_exec_hi", 64'(dut.r_state), 64'(S_EXEC_HI));
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("mid_rst_valid", 64'(rs_valid), 64'd0);
        chk("mid_rst_result", rs_result, 64'd0);
        chk("mid_rst_flags", 64'({rs_flags, flags_nzcv}), 64'd0);
        chk("mid_rst_misc", 64'({rs_err, rs_id, r0_ready, r1_ready}), 64'd0);
        chk("mid_rst_idle", 64'(dut.r_state), 64'(S_IDLE));
        @(posedge clk);
        #1;
        reset = 1'b0;
        sb_q.delete();
        m_flags = 4'd0;
        issue(1'b1, ALU_ADD, 1'b0, 1'b0, 64'd40, 64'd2);
        drain();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
